avalon_gpio_irq: RTL and testbench

- Parametrised Avalon-MM GPIO peripheral, the next generation of the board's button/microphone/status-LED interface.
- Generalises to N_IN debounced inputs and N_OUT outputs, with atomic set/clear of the output register.
- Adds per-channel edge detection (rising/falling selectable) with pending/enable registers and a level interrupt to the CPU.
- Sits on the Nios Avalon bus next to the audio front end; inputs are buttons, the mic comparator and similar asynchronous pins.

---
 rtl/avalon_gpio_irq.sv | 147 ++++++++++++++
 tb/tb_avalon_gpio_irq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : avalon_gpio_irq
// Brief    : Avalon-MM GPIO with debounced inputs, set/clear outputs and
//            per-channel edge interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_gpio_irq #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 10,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [2:0]        avs_s0_address,
  input  logic              avs_s0_write,
  input  logic              avs_s0_read,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic              avm_s0_irq,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out
);

  localparam logic [2:0] c_addr_out     = 3'd0;
  localparam logic [2:0] c_addr_set     = 3'd1;
  localparam logic [2:0] c_addr_clr     = 3'd2;
  localparam logic [2:0] c_addr_in      = 3'd3;
  localparam logic [2:0] c_addr_raw     = 3'd4;
  localparam logic [2:0] c_addr_irq_en  = 3'd5;
  localparam logic [2:0] c_addr_pend    = 3'd6;
  localparam logic [2:0] c_addr_edge    = 3'd7;

  localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] c_cnt_one = DEB_W'(1);

  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [N_IN-1:0]  w_deb;
  logic [N_IN-1:0]  r_deb_d;
  logic [N_IN-1:0]  r_irq_en;
  logic [N_IN-1:0]  r_pend;
  logic [N_IN-1:0]  r_rise_en;
  logic [N_IN-1:0]  r_fall_en;
  logic [N_IN-1:0]  w_evt;
  logic [N_IN-1:0]  w_clr;
  logic [N_OUT-1:0] r_out;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  // Upper write-data bits beyond each register's width are intentionally dropped.
  assign w_unused = ^avs_s0_writedata;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar g = 0; g < N_IN; g++) begin : g_deb
      logic [DEB_W-1:0] r_cnt;
      logic             r_state;

      always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
          r_cnt   <= '0;
          r_state <= 1'b0;
        end else if (r_sync2[g] == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_max) begin
          r_cnt   <= '0;
          r_state <= r_sync2[g];
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end

      assign w_deb[g] = r_state;
    end
  endgenerate

  always_comb begin
    w_evt = (w_deb & ~r_deb_d & r_rise_en) | (~w_deb & r_deb_d & r_fall_en);
    w_clr = '0;
    if (avs_s0_write && (avs_s0_address == c_addr_pend))
      w_clr = avs_s0_writedata[N_IN-1:0];
  end

  always_comb begin
    w_rd_val = '0;
    case (avs_s0_address)
      c_addr_out:    w_rd_val[N_OUT-1:0] = r_out;
      c_addr_in:     w_rd_val[N_IN-1:0]  = w_deb;
      c_addr_raw:    w_rd_val[N_IN-1:0]  = r_sync2;
      c_addr_irq_en: w_rd_val[N_IN-1:0]  = r_irq_en;
      c_addr_pend:   w_rd_val[N_IN-1:0]  = r_pend;
      c_addr_edge: begin
        w_rd_val[N_IN-1:0]     = r_rise_en;
        w_rd_val[16+N_IN-1:16] = r_fall_en;
      end
      default:       w_rd_val = '0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_deb_d   <= '0;
      r_pend    <= '0;
      r_out     <= '0;
      r_irq_en  <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_rdata   <= '0;
    end else begin
      r_deb_d <= w_deb;
      // A new event outranks a simultaneous write-1-to-clear.
      r_pend  <= (r_pend & ~w_clr) | w_evt;
      if (avs_s0_write) begin
        case (avs_s0_address)
          c_addr_out:    r_out    <= avs_s0_writedata[N_OUT-1:0];
          c_addr_set:    r_out    <= r_out | avs_s0_writedata[N_OUT-1:0];
          c_addr_clr:    r_out    <= r_out & ~avs_s0_writedata[N_OUT-1:0];
          c_addr_irq_en: r_irq_en <= avs_s0_writedata[N_IN-1:0];
          c_addr_edge: begin
            r_rise_en <= avs_s0_writedata[N_IN-1:0];
            r_fall_en <= avs_s0_writedata[16+N_IN-1:16];
          end
          default: ;
        endcase
      end
      r_rdata <= avs_s0_read ? w_rd_val : 32'd0;
    end
  end

  assign avs_s0_readdata = r_rdata;
  assign avm_s0_irq      = |(r_pend & r_irq_en);
  assign gpio_out        = r_out;

endmodule
`default_nettype wire

// File: tb/tb_avalon_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_gpio_irq
// Brief    : Scoreboard bench for avalon_gpio_irq with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_gpio_irq;
  localparam int N_IN  = 4;
  localparam int N_OUT = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [2:0]        addr = '0;
  logic              wr_s = 1'b0;
  logic              rd_s = 1'b0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              irq;
  logic [N_IN-1:0]   gin = '0;
  logic [N_OUT-1:0]  gout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        was_rd = 1'b0;
  logic [31:0] m_exp;
  string       m_nm;

  always #5 clk = ~clk;

  avalon_gpio_irq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DEB_CYCLES(8), .DEB_W(4)
  ) dut (
    .csi_clk(clk),
    .rsi_reset_n(rst_n),
    .avs_s0_address(addr),
    .avs_s0_write(wr_s),
    .avs_s0_read(rd_s),
    .avs_s0_writedata(wdata),
    .avs_s0_readdata(rdata),
    .avm_s0_irq(irq),
    .gpio_in(gin),
    .gpio_out(gout)
  );

  // Remember whether the DUT sampled a read on the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) was_rd <= 1'b0;
    else        was_rd <= rd_s;
  end

  always @(negedge clk) begin
    if (was_rd) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected act=0x%08h exp=<none>", rdata);
      end else begin
        m_exp = exp_q.pop_front();
        m_nm  = name_q.pop_front();
        if (rdata !== m_exp) begin
          n_fail++;
          $display("FAIL %s act=0x%08h exp=0x%08h", m_nm, rdata, m_exp);
        end
      end
    end else begin
      n_tests++;
      if (rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL rd_idle act=0x%08h exp=0x00000000", rdata);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_s = 1'b1;
    @(negedge clk);
    wr_s = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    addr = a; rd_s = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    rd_s = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e,
                      input string nm);
    addr = a; wdata = d; wr_s = 1'b1; rd_s = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    wr_s = 1'b0; rd_s = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%08h exp=0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    // Reset with all pins high; sync/debounce must stay cleared.
    #1 rst_n = 1'b0;
    gin = 4'hF;
    tick(3);
    chk("rst_gpio_out", 32'(gout), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    rd(3'd4, 32'h0, "rst_raw");
    rd(3'd3, 32'h0, "rst_in");
    rd(3'd0, 32'h0, "rst_out");
    rd(3'd1, 32'h0, "rst_set");
    rd(3'd2, 32'h0, "rst_clr");
    rd(3'd5, 32'h0, "rst_irq_en");
    rd(3'd6, 32'h0, "rst_pend");
    rd(3'd7, 32'h0, "rst_edge");
    tick(4);
    rd(3'd3, 32'hF, "held_high_in");
    rd(3'd4, 32'hF, "held_high_raw");
    rd(3'd6, 32'h0, "held_high_no_pend");
    gin = 4'h0;
    tick(14);
    rd(3'd3, 32'h0, "all_low_in");
    rd(3'd6, 32'h0, "all_low_no_pend");

    // Output register and atomic set/clear.
    wr(3'd0, 32'hFFFF_F0F0);
    wr(3'd1, 32'h0000_0003);
    wr(3'd2, 32'h0000_0010);
    chk("out_setclr_pins", 32'(gout), 32'h0E3);
    rd(3'd0, 32'h0E3, "out_setclr_read");
    rdwr(3'd0, 32'h155, 32'h0E3, "rdwr_prewrite");
    rd(3'd0, 32'h155, "rdwr_postwrite");
    chk("out_pins_155", 32'(gout), 32'h155);
    rd(3'd1, 32'h0, "set_reads_zero");
    rd(3'd2, 32'h0, "clr_reads_zero");

    // Debounce: short glitch rejected, long hold accepted at the exact cycle.
    gin[0] = 1'b1;
    tick(6);
    gin[0] = 1'b0;
    tick(12);
    rd(3'd3, 32'h0, "glitch_rejected");
    gin[0] = 1'b1;
    tick(1);
    rd(3'd4, 32'h0, "raw_before");
    rd(3'd4, 32'h1, "raw_after");
    tick(6);
    rd(3'd3, 32'h0, "in_before");
    rd(3'd3, 32'h1, "in_after");
    tick(9);
    gin[0] = 1'b0;
    tick(12);
    rd(3'd3, 32'h0, "in_released");

    // Rising and falling edge interrupts on channel 0.
    wr(3'd7, 32'h0001_0001);
    wr(3'd5, 32'h1);
    gin[0] = 1'b1;
    tick(10);
    chk("rise_irq_before", 32'(irq), 32'h0);
    tick(1);
    chk("rise_irq_after", 32'(irq), 32'h1);
    rd(3'd6, 32'h1, "rise_pend");
    wr(3'd6, 32'h1);
    chk("w1c_irq_low", 32'(irq), 32'h0);
    rd(3'd6, 32'h0, "w1c_pend_clear");
    gin[0] = 1'b0;
    tick(12);
    chk("fall_irq", 32'(irq), 32'h1);
    rd(3'd6, 32'h1, "fall_pend");
    wr(3'd6, 32'h1);
    chk("fall_w1c_irq_low", 32'(irq), 32'h0);

    // Masked pending, late enable, and W1C colliding with a new event.
    wr(3'd5, 32'h0);
    wr(3'd7, 32'h2);
    gin[1] = 1'b1;
    tick(12);
    chk("masked_irq_low", 32'(irq), 32'h0);
    rd(3'd6, 32'h2, "masked_pend");
    wr(3'd5, 32'h2);
    chk("late_enable_irq", 32'(irq), 32'h1);
    wr(3'd6, 32'h2);
    chk("ch1_w1c_irq_low", 32'(irq), 32'h0);
    gin[1] = 1'b0;
    tick(12);
    rd(3'd6, 32'h0, "fall_disabled_no_pend");
    gin[1] = 1'b1;
    tick(10);
    wr(3'd6, 32'h2);
    rd(3'd6, 32'h2, "set_beats_w1c");
    chk("set_beats_w1c_irq", 32'(irq), 32'h1);
    wr(3'd6, 32'h2);
    rd(3'd6, 32'h0, "w1c_no_event");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'h000F_000F, "edge_sel_width");
    rd(3'd6, 32'h0, "edge_sel_no_event");
    rd(3'd3, 32'h2, "in_ch1_high");
    rd(3'd5, 32'h2, "irq_en_read");

    // Asynchronous reset in the middle of a debounce count.
    wr(3'd0, 32'h3FF);
    wr(3'd5, 32'h4);
    gin[2] = 1'b1;
    tick(12);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_out", 32'(gout), 32'h3FF);
    gin[3] = 1'b1;
    tick(4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(gout), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    rd(3'd5, 32'h0, "post_rst_irq_en");
    rd(3'd6, 32'h0, "post_rst_pend");
    rd(3'd0, 32'h0, "post_rst_out");
    rd(3'd7, 32'h0, "post_rst_edge");
    rd(3'd3, 32'h0, "post_rst_in");
    tick(10);
    rd(3'd3, 32'hE, "post_rst_in_settled");
    rd(3'd6, 32'h0, "post_rst_no_pend");
    chk("post_rst_irq", 32'(irq), 32'h0);

    tick(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
